digit_scan_ctrl: RTL and testbench
==================================

# digit_scan_ctrl

Time-multiplexed scan controller for the board's 4-digit 7-segment display. It generates the 2-bit digit select that drives the downstream 4:1 digit/segment multiplexer, and the matching active-low anode enables. Each slot includes a blanking interval to suppress ghosting, and digits whose enable bit is clear are skipped. It sits directly upstream of the display mux, between the system clock and the segment-data path.

## Interface
- DIV, 50000: slot length in clk cycles (1 kHz digit rate at 50 MHz); legal range DIV ≥ 2.
- BLANK, 1000: cycles at the start of each slot with all anodes off; legal range 0 ≤ BLANK < DIV; 0 disables blanking.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  scan enable; low freezes scanning and blanks the display.
- digit_en  input  4  per-digit enable; bit i enables digit i.
- sel  output  2  digit index to the downstream mux select.
- an  output  4  anode enables, active low; bit i drives digit i.
- tick  output  1  one-cycle pulse on each slot advance.
- frame  output  1  one-cycle pulse when the scan wraps to the start of a new frame.

## Operation
- Internal slot counter cnt, width clog2(DIV), counts 0..DIV-1.
- All outputs are registers; there is no combinational path from any input to any output.
- Reset values: cnt=0, sel=2'b00, an=4'b1111, tick=0, frame=0.
- While en=1:
  - cnt increments each cycle.
  - When cnt reaches DIV-1, cnt goes to 0 and a slot advance occurs.
- Slot advance:
  - sel moves to the next index above the current one, modulo 4, whose digit_en bit is 1.
  - If only the current digit is enabled, sel is unchanged.
  - tick=1 on every advance.
  - frame=1 when the new sel ≤ old sel numerically; this includes the single-enabled-digit case.
- If digit_en=4'b0000 at the advance:
  - sel holds.
  - tick=0 and frame=0.
  - cnt still wraps.
- While en=0:
  - cnt and sel hold.
  - tick=0 and frame=0.
  - an=4'b1111.
- Re-asserting en resumes from the held cnt and sel; there is no restart.
- Invariant, true in every cycle after reset: an = 4'b1111 when any of the following holds, otherwise an = ~(4'b0001 << sel):
  - the en value registered at the last edge was 0;
  - cnt < BLANK;
  - digit_en[sel] as sampled at the last edge was 0.
- Clearing digit_en[sel] mid-slot blanks that digit from the next edge for the remainder of the slot. sel does not change until the slot advance.
- Setting a digit_en bit takes effect at the next slot advance, or immediately on an if it is the current sel's bit.

## Timing
- Slot period is exactly DIV cycles. A full frame is DIV × (number of enabled digits) cycles.
- sel, an, tick and frame update on the same edge. tick and frame are high in exactly the cycle where the new sel is first presented and cnt=0.
- an is lit for DIV−BLANK cycles per slot, from cnt=BLANK through cnt=DIV−1.
- Anode decode is registered, so an is glitch-free across sel transitions. During the cycle in which sel changes, an is never low for the old digit and the new digit simultaneously.
- Reset asserted mid-slot: on the next edge all state returns to reset values regardless of en. Scanning restarts at sel=0, cnt=0.
- After rst deasserts with en=1 and digit_en=4'b1111:
  - the first tick occurs DIV cycles later, with sel=1;
  - with BLANK>0, the first lit anode is an=4'b1110, at cnt=BLANK of slot 0.
- en held low: tick and frame stay 0 indefinitely, and cnt does not wrap.

## Test plan
All scenarios use DIV=8, BLANK=2.
- Reset and free run, digit_en=4'b1111, en=1: sel sequence 0,1,2,3,0 with each value held 8 cycles. an=4'b1111 at cnt 0–1 and ~(1<<sel) at cnt 2–7. tick every 8 cycles. frame only on 3→0, every 32 cycles.
- Skip, digit_en=4'b1010: sel alternates 1,3,1 at 8-cycle spacing. frame on each 3→1. an never drives bit 0 or bit 2 low.
- Single digit, digit_en=4'b0100: sel stays 2. tick and frame both pulse every 8 cycles. an toggles between 4'b1111 (2 cycles) and 4'b1011 (6 cycles).
- en dropped at cnt=5 for 10 cycles: an=4'b1111 from the next edge, cnt and sel frozen, no tick. After re-enable the slot completes 3 more cycles (cnt 5,6,7), then advances.
- digit_en=4'b0000 for one frame: an constant 4'b1111, sel constant, tick=frame=0. On restoring 4'b1111, the next advance moves sel to old sel+1.
- Reset asserted at cnt=4, sel=2: the next cycle shows sel=0, an=4'b1111, tick=0. The first tick occurs 8 cycles after rst deasserts.

Source files
------------

// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: time-multiplexed scan controller for a 4-digit
// 7-segment display. Produces the 2-bit digit select for the downstream
// mux plus registered active-low anode enables, with a blanking interval
// at the start of each slot and skipping of disabled digits.
module digit_scan_ctrl #(
  parameter int DIV   = 50000,  // slot length in clk cycles, >= 2
  parameter int BLANK = 1000    // blanked cycles at slot start, < DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] digit_en,
  output logic [1:0] sel,
  output logic [3:0] an,
  output logic       tick,
  output logic       frame
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);

  logic [CW-1:0] cnt_reg, cnt_next;
  logic [1:0]    sel_reg, sel_next;
  logic [3:0]    an_reg, an_next;
  logic          tick_reg, tick_next;
  logic          frame_reg, frame_next;

  logic          slot_end;
  logic          any_en;
  logic          lit_ok;
  logic [1:0]    next_enabled;

  // Candidate successors: sel+1, sel+2, sel+3 and sel itself (offset 4
  // wraps back to the current index), with their enable bits.
  logic [1:0]    cand_idx [1:4];
  logic [4:1]    cand_ok;

  genvar gi;
  generate
    for (gi = 1; gi <= 4; gi++) begin : g_cand
      assign cand_idx[gi] = sel_reg + 2'(gi);
      assign cand_ok[gi]  = digit_en[cand_idx[gi]];
    end
  endgenerate

  // Pick the nearest enabled digit above the current one, modulo 4.
  // Iterating from the farthest offset lets the nearest one win.
  always_comb begin
    next_enabled = sel_reg;
    for (int k = 4; k >= 1; k--) begin
      if (cand_ok[k]) next_enabled = cand_idx[k];
    end
  end

  assign any_en   = |digit_en;
  assign slot_end = (cnt_reg == CNT_LAST);

  // Next-state for counter, select and the tick/frame pulses.
  always_comb begin
    cnt_next   = cnt_reg;
    sel_next   = sel_reg;
    tick_next  = 1'b0;
    frame_next = 1'b0;
    if (en) begin
      if (slot_end) begin
        cnt_next = '0;
        // With no digit enabled the slot still wraps but nothing advances.
        if (any_en) begin
          sel_next   = next_enabled;
          tick_next  = 1'b1;
          frame_next = (next_enabled <= sel_reg);
        end
      end else begin
        cnt_next = cnt_reg + CW'(1);
      end
    end
  end

  // Anode lit only when scanning, past the blanking window, and the
  // selected digit is enabled as sampled on this edge.
  assign lit_ok = en && (cnt_next >= CNT_BLANK) && digit_en[sel_next];

  // Registered one-hot-low anode decode of the upcoming select, so the
  // anodes switch on the same edge as sel and never overlap.
  generate
    for (gi = 0; gi < 4; gi++) begin : g_an
      assign an_next[gi] = ~(lit_ok && (sel_next == 2'(gi)));
    end
  endgenerate

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg   <= '0;
      sel_reg   <= 2'b00;
      an_reg    <= 4'b1111;
      tick_reg  <= 1'b0;
      frame_reg <= 1'b0;
    end else begin
      cnt_reg   <= cnt_next;
      sel_reg   <= sel_next;
      an_reg    <= an_next;
      tick_reg  <= tick_next;
      frame_reg <= frame_next;
    end
  end

  assign sel   = sel_reg;
  assign an    = an_reg;
  assign tick  = tick_reg;
  assign frame = frame_reg;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Testbench for digit_scan_ctrl with DIV=8, BLANK=2. Each vector holds the
// inputs applied before one rising edge and the outputs expected after it.
module tb_digit_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [3:0] digit_en = 4'b0000;
  logic [1:0] sel;
  logic [3:0] an;
  logic       tick;
  logic       frame;

  int n_tests = 0;
  int n_fail  = 0;

  digit_scan_ctrl #(.DIV(8), .BLANK(2)) dut (
    .clk(clk), .rst(rst), .en(en), .digit_en(digit_en),
    .sel(sel), .an(an), .tick(tick), .frame(frame)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] de;
    logic [1:0] sel;
    logic [3:0] an;
    logic       tick;
    logic       frame;
    string      tag;
  } vec_t;

  vec_t vq[$];

  function automatic logic [3:0] lit(input logic [1:0] s);
    return ~(4'b0001 << s);
  endfunction

  task automatic add(input logic r, input logic e, input logic [3:0] d,
                     input logic [1:0] s, input logic [3:0] a,
                     input logic t, input logic f, input string tag);
    vec_t v;
    v.rst = r; v.en = e; v.de = d; v.sel = s; v.an = a;
    v.tick = t; v.frame = f; v.tag = tag;
    vq.push_back(v);
  endtask

  // Free run with all digits enabled, k edges after reset.
  task automatic add_full(input int k, input string tag);
    int c, s;
    logic [1:0] sl;
    c = k % 8; s = k / 8; sl = 2'(s % 4);
    add(0, 1, 4'b1111, sl, (c < 2) ? 4'b1111 : lit(sl),
        c == 0, (c == 0) && (sl == 2'd0), tag);
  endtask

  task automatic chk(input int idx, input string name,
                     input logic [3:0] got, input logic [3:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL vec %0d %s: got %b expected %b", idx, name, got, exp);
    end
  endtask

  initial begin
    // Scenario 1: reset, free run, all digits.
    add(1, 0, 4'b1111, 0, 4'b1111, 0, 0, "reset");
    for (int k = 1; k <= 40; k++) add_full(k, "free_run");

    // Scenario 2: skip, digits 1 and 3 only.
    add(1, 0, 4'b1010, 0, 4'b1111, 0, 0, "reset");
    for (int k = 1; k <= 40; k++) begin
      int c, s;
      logic [1:0] sl;
      c = k % 8; s = k / 8;
      sl = (s == 0) ? 2'd0 : ((s % 2 == 1) ? 2'd1 : 2'd3);
      add(0, 1, 4'b1010, sl, (s == 0 || c < 2) ? 4'b1111 : lit(sl),
          (c == 0) && (s > 0), (c == 0) && (s % 2 == 1) && (s >= 3), "skip");
    end

    // Scenario 3: single digit 2.
    add(1, 0, 4'b0100, 0, 4'b1111, 0, 0, "reset");
    for (int k = 1; k <= 32; k++) begin
      int c, s;
      logic [1:0] sl;
      c = k % 8; s = k / 8;
      sl = (s == 0) ? 2'd0 : 2'd2;
      add(0, 1, 4'b0100, sl, (s == 0 || c < 2) ? 4'b1111 : 4'b1011,
          (c == 0) && (s > 0), (c == 0) && (s >= 2), "single");
    end

    // Scenario 4: en dropped at cnt=5 for 10 cycles.
    add(1, 0, 4'b1111, 0, 4'b1111, 0, 0, "reset");
    for (int k = 1; k <= 5; k++) add_full(k, "pre_hold");
    for (int k = 0; k < 10; k++) add(0, 0, 4'b1111, 0, 4'b1111, 0, 0, "hold");
    add(0, 1, 4'b1111, 0, 4'b1110, 0, 0, "resume_cnt6");
    add(0, 1, 4'b1111, 0, 4'b1110, 0, 0, "resume_cnt7");
    add(0, 1, 4'b1111, 1, 4'b1111, 1, 0, "resume_adv");
    add(0, 1, 4'b1111, 1, 4'b1111, 0, 0, "resume_cnt1");
    add(0, 1, 4'b1111, 1, 4'b1101, 0, 0, "resume_cnt2");

    // Scenario 5: no digits enabled for one frame, then restore.
    add(1, 0, 4'b1111, 0, 4'b1111, 0, 0, "reset");
    for (int k = 1; k <= 12; k++) add_full(k, "pre_off");
    for (int k = 0; k < 32; k++) add(0, 1, 4'b0000, 1, 4'b1111, 0, 0, "all_off");
    add(0, 1, 4'b1111, 1, 4'b1101, 0, 0, "restore_cnt5");
    add(0, 1, 4'b1111, 1, 4'b1101, 0, 0, "restore_cnt6");
    add(0, 1, 4'b1111, 1, 4'b1101, 0, 0, "restore_cnt7");
    add(0, 1, 4'b1111, 2, 4'b1111, 1, 0, "restore_adv");
    add(0, 1, 4'b1111, 2, 4'b1111, 0, 0, "restore_cnt1");
    add(0, 1, 4'b1111, 2, 4'b1011, 0, 0, "restore_cnt2");

    // Scenario 6: reset mid-slot at cnt=4, sel=2, with en still high.
    add(1, 0, 4'b1111, 0, 4'b1111, 0, 0, "reset");
    for (int k = 1; k <= 20; k++) add_full(k, "pre_rst");
    add(1, 1, 4'b1111, 0, 4'b1111, 0, 0, "mid_rst");
    for (int k = 1; k <= 8; k++) add_full(k, "post_rst");

    // Apply every vector: drive, clock, sample 1 time unit after the edge.
    for (int i = 0; i < vq.size(); i++) begin
      rst      = vq[i].rst;
      en       = vq[i].en;
      digit_en = vq[i].de;
      @(posedge clk);
      #1;
      chk(i, {vq[i].tag, ".sel"},   {2'b00, sel},   {2'b00, vq[i].sel});
      chk(i, {vq[i].tag, ".an"},    an,             vq[i].an);
      chk(i, {vq[i].tag, ".tick"},  {3'b000, tick}, {3'b000, vq[i].tick});
      chk(i, {vq[i].tag, ".frame"}, {3'b000, frame},{3'b000, vq[i].frame});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
